// File: rtl/count_event_monitor.sv
// Counter event monitor: detects compare matches and 255->0 wraps on an upstream
// count while armed, and queues type/timestamp events in a small FIFO.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | not monitoring; prev holds, no detection
// S_PRIME | one cycle loading prev so the first armed compare has history
// S_ARMED | detecting MATCH / WRAP events into the FIFO
module count_event_monitor #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count_in,
  input  logic [7:0] cmp_val,
  input  logic       arm,
  input  logic       disarm,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_type,
  output logic [7:0] evt_stamp,
  output logic       fifo_full,
  output logic [3:0] drop_cnt,
  output logic       armed
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_ARMED} state_t;

  state_t        r_state;
  logic [7:0]    r_prev;
  logic [7:0]    r_ts;
  logic [1:0]    r_type  [DEPTH];
  logic [7:0]    r_stamp [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [3:0]    r_drop;

  logic       w_detect_en;
  logic       w_match;
  logic       w_wrap;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_accept;
  logic       w_drop;
  logic [1:0] w_type;

  assign w_detect_en = (r_state == S_ARMED) && !disarm;
  assign w_match     = (count_in == cmp_val) && (count_in != r_prev);
  assign w_wrap      = (r_prev == 8'hFF) && (count_in == 8'h00);
  assign w_push      = w_detect_en && (w_match || w_wrap);
  assign w_type      = {w_wrap, w_match};
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = (r_count != '0) && evt_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_accept    = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (arm && !disarm) r_state <= S_PRIME;
        S_PRIME: r_state <= disarm ? S_IDLE : S_ARMED;
        S_ARMED: if (disarm) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 8'h00;
      r_ts   <= 8'h00;
    end else begin
      r_ts <= r_ts + 8'd1;
      if (r_state != S_IDLE) r_prev <= count_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_type[r_wr_ptr]  <= w_type;
      r_stamp[r_wr_ptr] <= r_ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 4'h0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 4'hF)) r_drop <= r_drop + 4'd1;
    end
  end

  assign evt_valid = (r_count != '0);
  assign evt_type  = evt_valid ? r_type[r_rd_ptr]  : 2'b00;
  assign evt_stamp = evt_valid ? r_stamp[r_rd_ptr] : 8'h00;
  assign fifo_full = w_full;
  assign drop_cnt  = r_drop;
  assign armed     = (r_state == S_ARMED);

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: detection, FIFO ordering, overflow,
// disarm persistence and reset behaviour, with hand-computed expectations.
module tb_count_event_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] count_in = 8'd0;
  logic [7:0] cmp_val = 8'd0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [7:0] evt_stamp;
  logic       fifo_full;
  logic [3:0] drop_cnt;
  logic       armed;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] ts_m;
  logic [7:0] s [8];
  logic [7:0] sx, sa, sb;

  count_event_monitor #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .cmp_val(cmp_val),
    .arm(arm), .disarm(disarm), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_type(evt_type), .evt_stamp(evt_stamp),
    .fifo_full(fifo_full), .drop_cnt(drop_cnt), .armed(armed)
  );

  always #5 clk = ~clk;

  // Expected free-running timestamp: cycles since the last reset edge.
  always @(posedge clk) begin
    if (rst) ts_m <= 8'd0;
    else     ts_m <= ts_m + 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", evt_valid); end
    n_tests++; if (evt_type !== 2'b00) begin n_fail++; $display("FAIL reset_type: got %0b want 00", evt_type); end
    n_tests++; if (evt_stamp !== 8'h00) begin n_fail++; $display("FAIL reset_stamp: got %0h want 00", evt_stamp); end
    n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", fifo_full); end
    n_tests++; if (drop_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed: got %0b want 0", armed); end
  endtask

  task automatic test_match();
    cmp_val  = 8'd50;
    count_in = 8'd0;
    do_arm();
    n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL match_armed: got %0b want 1", armed); end
    for (int v = 48; v <= 52; v++) begin
      count_in = 8'(v);
      if (v == 50) sx = ts_m;
      tick();
      if (v == 50) begin
        n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL match_latency: got %0b want 1", evt_valid); end
      end
    end
    n_tests++; if (evt_type !== 2'b01) begin n_fail++; $display("FAIL match_type: got %0b want 01", evt_type); end
    n_tests++; if (evt_stamp !== sx) begin n_fail++; $display("FAIL match_stamp: got %0h want %0h", evt_stamp, sx); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL match_single: got %0b want 0", evt_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4];
    seq[0] = 8'd254; seq[1] = 8'd255; seq[2] = 8'd0; seq[3] = 8'd1;
    for (int pass = 0; pass < 2; pass++) begin
      cmp_val = (pass == 0) ? 8'd0 : 8'd100;
      for (int i = 0; i < 4; i++) begin
        count_in = seq[i];
        if (i == 2) sx = ts_m;
        tick();
      end
      n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid%0d: got %0b want 1", pass, evt_valid); end
      n_tests++; if (evt_type !== ((pass == 0) ? 2'b11 : 2'b10)) begin n_fail++; $display("FAIL wrap_type%0d: got %0b want %0b", pass, evt_type, (pass == 0) ? 2'b11 : 2'b10); end
      n_tests++; if (evt_stamp !== sx) begin n_fail++; $display("FAIL wrap_stamp%0d: got %0h want %0h", pass, evt_stamp, sx); end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_single%0d: got %0b want 0", pass, evt_valid); end
    end
  endtask

  task automatic test_hold();
    cmp_val  = 8'd50;
    count_in = 8'd50;
    sx = ts_m;
    for (int i = 0; i < 5; i++) tick();
    n_tests++; if (evt_type !== 2'b01) begin n_fail++; $display("FAIL hold_type: got %0b want 01", evt_type); end
    n_tests++; if (evt_stamp !== sx) begin n_fail++; $display("FAIL hold_stamp: got %0h want %0h", evt_stamp, sx); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL hold_single: got %0b want 0", evt_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      count_in = 8'd0;
      tick();
      count_in = 8'd50;
      s[i] = ts_m;
      tick();
    end
    n_tests++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %0b want 1", fifo_full); end
    n_tests++; if (drop_cnt !== 4'd2) begin n_fail++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_pop_valid%0d: got %0b want 1", i, evt_valid); end
      n_tests++; if (evt_stamp !== s[i]) begin n_fail++; $display("FAIL ovf_pop_stamp%0d: got %0h want %0h", i, evt_stamp, s[i]); end
      tick();
    end
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %0b want 0", evt_valid); end
    n_tests++; if (evt_type !== 2'b00) begin n_fail++; $display("FAIL ovf_empty_type: got %0b want 00", evt_type); end
    n_tests++; if (evt_stamp !== 8'h00) begin n_fail++; $display("FAIL ovf_empty_stamp: got %0h want 00", evt_stamp); end
    n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL ovf_empty_full: got %0b want 0", fifo_full); end
    tick();
    tick();
    evt_ready = 1'b0;
    count_in = 8'd0;
    tick();
    count_in = 8'd50;
    sx = ts_m;
    tick();
    n_tests++; if (evt_stamp !== sx) begin n_fail++; $display("FAIL ready_idle_stamp: got %0h want %0h", evt_stamp, sx); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ready_idle_empty: got %0b want 0", evt_valid); end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 4; i++) begin
      count_in = 8'd0;
      tick();
      count_in = 8'd50;
      s[i] = ts_m;
      tick();
    end
    count_in = 8'd0;
    tick();
    count_in  = 8'd50;
    evt_ready = 1'b1;
    s[4] = ts_m;
    tick();
    evt_ready = 1'b0;
    n_tests++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL pp_full: got %0b want 1", fifo_full); end
    n_tests++; if (drop_cnt !== 4'd2) begin n_fail++; $display("FAIL pp_drop: got %0d want 2", drop_cnt); end
    evt_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_tests++; if (evt_stamp !== s[i]) begin n_fail++; $display("FAIL pp_order%0d: got %0h want %0h", i, evt_stamp, s[i]); end
      tick();
    end
    evt_ready = 1'b0;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %0b want 0", evt_valid); end
  endtask

  task automatic test_one_entry();
    count_in = 8'd0;
    tick();
    count_in = 8'd50;
    sa = ts_m;
    tick();
    count_in = 8'd0;
    tick();
    count_in  = 8'd50;
    evt_ready = 1'b1;
    sb = ts_m;
    tick();
    evt_ready = 1'b0;
    n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL one_valid: got %0b want 1", evt_valid); end
    n_tests++; if (evt_stamp !== sb) begin n_fail++; $display("FAIL one_stamp: got %0h want %0h (old %0h)", evt_stamp, sb, sa); end
  endtask

  task automatic test_disarm();
    count_in = 8'd0;
    tick();
    count_in = 8'd50;
    disarm   = 1'b1;
    tick();
    disarm = 1'b0;
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL disarm_armed: got %0b want 0", armed); end
    n_tests++; if (evt_stamp !== sb) begin n_fail++; $display("FAIL disarm_keep: got %0h want %0h", evt_stamp, sb); end
    n_tests++; if (drop_cnt !== 4'd2) begin n_fail++; $display("FAIL disarm_drop: got %0d want 2", drop_cnt); end
    arm = 1'b1; disarm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0;
    tick();
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL armdisarm_idle: got %0b want 0", armed); end
    count_in = 8'd0;
    tick();
    count_in = 8'd50;
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL idle_nodetect: got %0b want 0", evt_valid); end
  endtask

  task automatic test_reset_mid();
    do_arm();
    for (int i = 0; i < 3; i++) begin
      count_in = 8'd0;
      tick();
      count_in = 8'd50;
      tick();
    end
    n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_queued: got %0b want 1", evt_valid); end
    count_in = 8'd0;
    tick();
    count_in  = 8'd50;
    evt_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    evt_ready = 1'b0;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b want 0", evt_valid); end
    n_tests++; if (drop_cnt !== 4'd0) begin n_fail++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL rmid_armed: got %0b want 0", armed); end
    n_tests++; if (evt_stamp !== 8'h00) begin n_fail++; $display("FAIL rmid_stamp: got %0h want 00", evt_stamp); end
  endtask

  task automatic test_saturate();
    do_arm();
    for (int i = 0; i < 21; i++) begin
      count_in = 8'd0;
      tick();
      count_in = 8'd50;
      if (i == 0) sx = ts_m;
      tick();
    end
    n_tests++; if (drop_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_drop: got %0d want 15", drop_cnt); end
    n_tests++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL sat_full: got %0b want 1", fifo_full); end
    n_tests++; if (evt_stamp !== sx) begin n_fail++; $display("FAIL sat_head: got %0h want %0h", evt_stamp, sx); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_match();
    test_wrap();
    test_hold();
    test_overflow();
    test_push_pop_full();
    test_one_entry();
    test_disarm();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
